// File: rtl/exp_sigma_table.sv
// exp_sigma_table: ping-pong table store between the exp-sigma generator and
// the risk datapath. The generator fills the shadow bank. The banks swap only
// when a fill finishes with every address written, so a lookup always reads a
// complete table.
module exp_sigma_table #(
    parameter int DATA_W = 17,
    parameter int ADDR_W = 6,
    parameter int DEPTH  = 64
) (
    input  logic              CLK,
    input  logic              iRST_n,
    input  logic              iStart,
    input  logic [DATA_W-1:0] iData,
    input  logic [ADDR_W-1:0] iAddr,
    input  logic              iValid,
    input  logic              iDone,
    input  logic              iRdReq,
    input  logic [ADDR_W-1:0] iRdAddr,
    output logic [DATA_W-1:0] oRdData,
    output logic              oRdValid,
    output logic              oRdErr,
    output logic              oReady,
    output logic              oBank,
    output logic [ADDR_W:0]   oFillCount,
    output logic              oFillErr
);

    localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W+1)'(DEPTH);

    // Both banks live in one array; the bank bit is the MSB of the index.
    logic [DATA_W-1:0] mem [0:2*DEPTH-1];
    logic [DEPTH-1:0]  mask;

    logic              wrEn;
    logic              newAddr;
    logic [ADDR_W:0]   cntNext;
    logic              fillFull;

    logic              rdV1;
    logic              rdErr1;
    logic              rdBank1;
    logic [ADDR_W-1:0] rdAddr1;

    // Write qualification and the fill count as it stands after this cycle's write.
    // A start in the same cycle drops the write, so a completion in that
    // cycle sees an empty fill.
    always_comb begin
        wrEn     = iValid & ~iStart;
        newAddr  = wrEn & ~mask[iAddr];
        cntNext  = oFillCount + {{ADDR_W{1'b0}}, newAddr};
        fillFull = ~iStart & (cntNext == FULL_COUNT);
    end

    // Shadow-bank write port. RAM contents are not reset.
    always_ff @(posedge CLK) begin
        if (wrEn)
            mem[{~oBank, iAddr}] <= iData;
    end

    // Track which addresses have been written, the fill count, and the bank swap.
    always_ff @(posedge CLK) begin
        if (!iRST_n) begin
            mask       <= '0;
            oFillCount <= '0;
            oReady     <= 1'b0;
            oBank      <= 1'b0;
            oFillErr   <= 1'b0;
        end else if (iStart) begin
            mask       <= '0;
            oFillCount <= '0;
            if (iDone)
                oFillErr <= 1'b1;
        end else begin
            if (newAddr)
                mask[iAddr] <= 1'b1;
            oFillCount <= cntNext;
            if (iDone) begin
                if (fillFull) begin
                    oBank      <= ~oBank;
                    oReady     <= 1'b1;
                    mask       <= '0;
                    oFillCount <= '0;
                end else begin
                    oFillErr <= 1'b1;
                end
            end
        end
    end

    // Read stage 1: capture the address, the active bank and the table status at request time.
    always_ff @(posedge CLK) begin
        if (!iRST_n) begin
            rdV1    <= 1'b0;
            rdErr1  <= 1'b0;
            rdBank1 <= 1'b0;
            rdAddr1 <= '0;
        end else begin
            rdV1    <= iRdReq;
            rdErr1  <= ~oReady;
            rdBank1 <= oBank;
            rdAddr1 <= iRdAddr;
        end
    end

    // Read stage 2: RAM access and the response. Data holds between responses.
    always_ff @(posedge CLK) begin
        if (!iRST_n) begin
            oRdData  <= '0;
            oRdValid <= 1'b0;
            oRdErr   <= 1'b0;
        end else begin
            oRdValid <= rdV1;
            oRdErr   <= rdV1 & rdErr1;
            if (rdV1)
                oRdData <= rdErr1 ? '0 : mem[{rdBank1, rdAddr1}];
        end
    end

endmodule

// File: tb/tb_exp_sigma_table.sv
// Directed bench for exp_sigma_table. Inputs are driven 1 ns after each
// rising edge, and outputs are sampled at the same point.
module tb_exp_sigma_table;

    localparam int DATA_W = 17;
    localparam int ADDR_W = 6;

    logic              CLK = 1'b0;
    logic              iRST_n = 1'b0;
    logic              iStart = 1'b0;
    logic [DATA_W-1:0] iData = '0;
    logic [ADDR_W-1:0] iAddr = '0;
    logic              iValid = 1'b0;
    logic              iDone = 1'b0;
    logic              iRdReq = 1'b0;
    logic [ADDR_W-1:0] iRdAddr = '0;
    logic [DATA_W-1:0] oRdData;
    logic              oRdValid;
    logic              oRdErr;
    logic              oReady;
    logic              oBank;
    logic [ADDR_W:0]   oFillCount;
    logic              oFillErr;

    int total = 0;
    int bad   = 0;

    exp_sigma_table #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(64)) dut (
        .CLK(CLK), .iRST_n(iRST_n), .iStart(iStart), .iData(iData), .iAddr(iAddr),
        .iValid(iValid), .iDone(iDone), .iRdReq(iRdReq), .iRdAddr(iRdAddr),
        .oRdData(oRdData), .oRdValid(oRdValid), .oRdErr(oRdErr), .oReady(oReady),
        .oBank(oBank), .oFillCount(oFillCount), .oFillErr(oFillErr)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Write every address except skip, with data = a*mul + add.
    task automatic doFill(input int mul, input int add, input int skip);
        for (int a = 0; a < 64; a++) begin
            if (a != skip) begin
                iValid = 1'b1;
                iAddr  = ADDR_W'(a);
                iData  = DATA_W'(a * mul + add);
                tick();
            end
        end
        iValid = 1'b0;
    endtask

    task automatic pulseStart();
        iStart = 1'b1;
        tick();
        iStart = 1'b0;
    endtask

    task automatic pulseDone();
        iDone = 1'b1;
        tick();
        iDone = 1'b0;
    endtask

    // Single lookup with latency 2; checks the response strobe, error and data.
    task automatic readCheck(input string tag, input int addr, input int expData, input bit expErr);
        iRdReq  = 1'b1;
        iRdAddr = ADDR_W'(addr);
        tick();
        iRdReq = 1'b0;
        check({tag, "_early"}, {31'd0, oRdValid}, 32'd0);
        tick();
        check({tag, "_valid"}, {31'd0, oRdValid}, 32'd1);
        check({tag, "_err"}, {31'd0, oRdErr}, {31'd0, expErr});
        check({tag, "_data"}, 32'(oRdData), 32'(expData));
    endtask

    initial begin
        // 1: reset state and a lookup with no valid table
        iRST_n = 1'b0;
        tick();
        iRST_n = 1'b1;
        check("rst_ready", {31'd0, oReady}, 32'd0);
        check("rst_bank", {31'd0, oBank}, 32'd0);
        check("rst_count", 32'(oFillCount), 32'd0);
        check("rst_fillerr", {31'd0, oFillErr}, 32'd0);
        check("rst_rdvalid", {31'd0, oRdValid}, 32'd0);
        check("rst_rderr", {31'd0, oRdErr}, 32'd0);
        check("rst_rddata", 32'(oRdData), 32'd0);
        readCheck("noTable", 5, 0, 1'b1);
        tick();
        check("noTable_after", {31'd0, oRdValid}, 32'd0);
        check("noTable_errdrop", {31'd0, oRdErr}, 32'd0);

        // 2: first complete fill, data = addr*100
        pulseStart();
        doFill(100, 0, -1);
        check("fill1_count", 32'(oFillCount), 32'd64);
        check("fill1_bank_pre", {31'd0, oBank}, 32'd0);
        pulseDone();
        check("fill1_ready", {31'd0, oReady}, 32'd1);
        check("fill1_bank", {31'd0, oBank}, 32'd1);
        check("fill1_count0", 32'(oFillCount), 32'd0);
        readCheck("fill1_rd63", 63, 6300, 1'b0);
        readCheck("fill1_rd0", 0, 0, 1'b0);

        // 3: second fill (data = addr+1) without iStart, reading addr 10 every cycle
        for (int k = 0; k < 68; k++) begin
            iRdReq  = 1'b1;
            iRdAddr = 6'd10;
            iValid  = (k < 64);
            iAddr   = ADDR_W'(k);
            iData   = DATA_W'(k + 1);
            iDone   = (k == 64);
            tick();
            if (k >= 1) begin
                check("stream_valid", {31'd0, oRdValid}, 32'd1);
                check("stream_data", 32'(oRdData), (k - 1 <= 64) ? 32'd1000 : 32'd11);
            end
            if (k == 63) check("stream_bank_pre", {31'd0, oBank}, 32'd1);
            if (k == 64) check("stream_bank_post", {31'd0, oBank}, 32'd0);
        end
        iRdReq = 1'b0;
        iValid = 1'b0;
        iDone  = 1'b0;
        tick();
        tick();
        check("stream_idle", {31'd0, oRdValid}, 32'd0);

        // 4: incomplete fill (addr 17 missing)
        pulseStart();
        doFill(1, 500, 17);
        pulseDone();
        check("short_fillerr", {31'd0, oFillErr}, 32'd1);
        check("short_count", 32'(oFillCount), 32'd63);
        check("short_bank", {31'd0, oBank}, 32'd0);
        check("short_ready", {31'd0, oReady}, 32'd1);
        readCheck("short_rd10", 10, 11, 1'b0);

        // 5: overwriting an address does not count twice
        pulseStart();
        iValid = 1'b1; iAddr = 6'd4; iData = 17'd7;
        tick();
        check("ovw_count1", 32'(oFillCount), 32'd1);
        iData = 17'd9;
        tick();
        iValid = 1'b0;
        check("ovw_count2", 32'(oFillCount), 32'd1);
        doFill(1, 2000, 4);
        check("ovw_count64", 32'(oFillCount), 32'd64);
        pulseDone();
        check("ovw_bank", {31'd0, oBank}, 32'd1);
        check("ovw_count0", 32'(oFillCount), 32'd0);
        check("ovw_fillerr_sticky", {31'd0, oFillErr}, 32'd1);
        readCheck("ovw_rd4", 4, 9, 1'b0);
        readCheck("ovw_rd5", 5, 2005, 1'b0);

        // a start coinciding with a write drops the write
        iValid = 1'b1; iAddr = 6'd0; iData = 17'd1;
        tick();
        iAddr = 6'd1;
        tick();
        check("startw_pre", 32'(oFillCount), 32'd2);
        iStart = 1'b1; iAddr = 6'd3;
        tick();
        iStart = 1'b0; iValid = 1'b0;
        check("startw_count", 32'(oFillCount), 32'd0);

        // 6: reset in the middle of a fill with a read in flight
        for (int a = 0; a < 30; a++) begin
            iValid = 1'b1;
            iAddr  = ADDR_W'(a);
            iData  = DATA_W'(a);
            tick();
        end
        iValid = 1'b0;
        check("mid_count", 32'(oFillCount), 32'd30);
        iRdReq = 1'b1; iRdAddr = 6'd4;
        tick();
        iRdReq = 1'b0;
        iRST_n = 1'b0;
        tick();
        iRST_n = 1'b1;
        check("mrst_rdvalid", {31'd0, oRdValid}, 32'd0);
        check("mrst_ready", {31'd0, oReady}, 32'd0);
        check("mrst_bank", {31'd0, oBank}, 32'd0);
        check("mrst_count", 32'(oFillCount), 32'd0);
        check("mrst_fillerr", {31'd0, oFillErr}, 32'd0);
        check("mrst_rddata", 32'(oRdData), 32'd0);
        tick();
        check("mrst_rdvalid2", {31'd0, oRdValid}, 32'd0);
        readCheck("mrst_rd", 4, 0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/exp_sigma_table.md
Name: exp_sigma_table

Overview:
- Consumer end of the exp-sigma generator stream: captures the 64-entry (addr, data, valid, done) table the generator writes and serves random-access lookups to the risk datapath.
- Ping-pong double buffer: lookups always read a complete table while the next one fills.
- Banks swap atomically only when a fill completes with every address written.

Parameters:
DATA_W, 17, width of a table entry (matches generator data output)
ADDR_W, 6, table address width
DEPTH, 64, entries per bank (equals 2**ADDR_W)

Ports:
CLK  in  1  clock, all logic on rising edge
iRST_n  in  1  synchronous active-low reset
iStart  in  1  one-cycle pulse marking the start of a new generator run
iData  in  DATA_W  table entry from generator
iAddr  in  ADDR_W  entry address from generator
iValid  in  1  write strobe for iData/iAddr
iDone  in  1  one-cycle pulse, generator finished
iRdReq  in  1  lookup request
iRdAddr  in  ADDR_W  lookup address
oRdData  out  DATA_W  lookup result
oRdValid  out  1  one-cycle response strobe
oRdErr  out  1  response carries no valid table (qualified by oRdValid)
oReady  out  1  active bank holds a complete table
oBank  out  1  index of the active (read) bank
oFillCount  out  ADDR_W+1  distinct addresses written in the shadow bank
oFillErr  out  1  sticky: iDone arrived with an incomplete fill

Behaviour:
- Reset (iRST_n=0 at a clock edge): next cycle oRdData=0, oRdValid=0, oRdErr=0, oReady=0, oBank=0, oFillCount=0, oFillErr=0. Written-mask cleared and in-flight read responses discarded. RAM contents are not reset.
- Storage: 2 banks x DEPTH x DATA_W. Shadow bank = ~oBank.
- Write path, iValid=1:
  - iData is written to shadow[iAddr].
  - If mask[iAddr]=0: set it and increment oFillCount.
  - If mask[iAddr]=1: overwrite the data; count unchanged.
- iStart:
  - Clears the mask and oFillCount.
  - If iValid is high in the same cycle, start wins: that write is dropped.
  - Does not affect oReady, oBank or oFillErr.
- iDone completion: the count used includes any valid write in the same cycle.
  - If the count equals DEPTH: next cycle oBank toggles, oReady=1, mask and oFillCount are cleared.
  - Otherwise: oFillErr=1 (cleared only by reset), no swap, mask and count are kept.
- After a swap, a fill may start without iStart, because the mask is already clear.
- Read pipeline, fixed latency 2:
  - Request at cycle N samples iRdAddr, oBank and oReady.
  - At N+2: oRdValid=1 for one cycle.
  - If oReady was 1 at N: oRdData = bank[oBank@N][iRdAddr@N], oRdErr=0.
  - If oReady was 0 at N: oRdData=0, oRdErr=1.
- Throughput: one request per cycle, back-to-back with no bubbles. No backpressure; the requester must accept every response.
- Read/swap collision: a request in the swap cycle reads the old bank. The first request after oBank changes reads the new bank.
- Reads never target the shadow bank, so there is no read/write hazard.
- Without a response, oRdData holds its last value and oRdErr=0.
- Reset mid-fill or mid-read: everything returns to reset values; any table previously in use is invalid (oReady=0).

Test Plan:
1. Reset, then iRdReq addr 5 -> 2 cycles later oRdValid=1, oRdErr=1, oRdData=0. Before that, oReady=0 and oBank=0.
2. iStart, 64 writes data=addr*100, then iDone -> next cycle oReady=1, oBank=1, oFillCount=0. Read addr 63 -> 6300; read addr 0 -> 0.
3. Second fill with data=addr+1 while reading addr 10 every cycle -> responses are 1000 every cycle, with no gaps, through the swap cycle. The first request after oBank returns to 0 returns 11.
4. Fill skipping addr 17 (63 writes) then iDone -> oFillErr=1, oFillCount=63, oBank unchanged, reads return the previous table.
5. Write addr 4 with 7 then with 9, then the remaining 63 addresses, then iDone -> swap occurs (count reaches 64, not 65); read addr 4 -> 9. Also: iStart with iValid in the same cycle -> the write is dropped and oFillCount=0.
6. iRST_n=0 after 30 writes, with a read in flight -> next cycle all outputs 0, oRdValid does not pulse, oReady=0.
